// File: rtl/serial_addsub_if.sv
// -----------------------------------------------------------------------------
// serial_addsub_if
//   Request/result bundle for serial_addsub.
//   master : drives start, sub, x, y, ci; observes busy, done, s, cu, ovf
//   slave  : the arithmetic unit (opposite directions)
//   N      : operand/result width
// -----------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int N = 16
);
    logic         start;
    logic         sub;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cu;
    logic         ovf;

    modport master (
        output start, sub, x, y, ci,
        input  busy, done, s, cu, ovf
    );

    modport slave (
        input  start, sub, x, y, ci,
        output busy, done, s, cu, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle adder/subtractor: adds x and (sub ? ~y : y) plus ci, K bits per
//   clock, with the inter-chunk carry held in a register. Latency N/K cycles
//   from the accepting edge to the done pulse.
//
//   Parameters
//     N : operand/result width (positive multiple of K)
//     K : chunk width per cycle (1..N)
//   Ports
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     bus     : serial_addsub_if.slave
//               start/sub/x/y/ci in; busy/done/s/cu/ovf out
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    serial_addsub_if.slave bus
);

    localparam int M  = N / K;
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_xa;
    logic [N-1:0]   r_yb;
    logic [N-1:0]   r_work;
    logic           r_c;
    logic [IW-1:0]  r_idx;
    logic [N-1:0]   r_s;
    logic           r_cu;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;

    logic [K-1:0]   w_xc;
    logic [K-1:0]   w_yc;
    logic [K:0]     w_sum;
    logic           w_c_msb;
    logic           w_last;
    logic [N-1:0]   w_work_next;

    // One K-bit slice of the full adder per cycle.
    always_comb begin
        w_xc        = r_xa[r_idx*K +: K];
        w_yc        = r_yb[r_idx*K +: K];
        w_sum       = {1'b0, w_xc} + {1'b0, w_yc} + {{K{1'b0}}, r_c};
        // Carry into the chunk's top bit: sum bit = a ^ b ^ carry_in.
        w_c_msb     = w_xc[K-1] ^ w_yc[K-1] ^ w_sum[K-1];
        w_last      = (r_idx == IW'(M - 1));
        w_work_next = r_work;
        w_work_next[r_idx*K +: K] = w_sum[K-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_xa    <= '0;
            r_yb    <= '0;
            r_work  <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_cu    <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_xa    <= bus.x;
                        r_yb    <= bus.sub ? ~bus.y : bus.y;
                        r_c     <= bus.ci;
                        r_idx   <= '0;
                        r_work  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                RUN: begin
                    r_work <= w_work_next;
                    r_c    <= w_sum[K];
                    if (w_last) begin
                        // Result registers load on the same edge that
                        // processes the last chunk, so they are valid
                        // for the whole DONE cycle.
                        r_s     <= w_work_next;
                        r_cu    <= w_sum[K];
                        r_ovf   <= w_c_msb ^ w_sum[K];
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.cu   = r_cu;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Bench for serial_addsub: N=16/K=4 directed, handshake, reset and random
//   operations; N=4/K=1 and N=4/K=4 exhaustive against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub_if #(.N(16)) ifa ();
    serial_addsub_if #(.N(4))  ifb ();
    serial_addsub_if #(.N(4))  ifc ();

    serial_addsub #(.N(16), .K(4)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa.slave));
    serial_addsub #(.N(4),  .K(1)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb.slave));
    serial_addsub #(.N(4),  .K(4)) dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] held_s;
    logic        held_cu;
    logic        held_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {cu,s} = x + (sub ? ~y : y) + ci mod 2^(n+1); ovf when the signed sum
    // of the two n-bit addends plus ci leaves the n-bit signed range.
    function automatic void model(input int n, input logic [15:0] x, input logic [15:0] y,
                                  input logic sub, input logic ci,
                                  output logic [15:0] s, output logic cu, output logic ovf);
        longint mask, half, a, b, t, sa, sb, ts;
        mask = (longint'(1) << n) - 1;
        half = longint'(1) << (n - 1);
        a    = longint'(x) & mask;
        b    = (sub ? longint'(~y) : longint'(y)) & mask;
        t    = a + b + longint'(ci);
        s    = 16'(t & mask);
        cu   = ((t >> n) & 1) != 0;
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        ts   = sa + sb + longint'(ci);
        ovf  = (ts >= half) || (ts < -half);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start16(input logic [15:0] x, input logic [15:0] y,
                           input logic sub, input logic ci, output int unsigned e0);
        ifa.start = 1'b1;
        ifa.x = x; ifa.y = y; ifa.sub = sub; ifa.ci = ci;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        ifa.start = 1'b0;
        ifa.x   = 16'($urandom);
        ifa.y   = 16'($urandom);
        ifa.sub = 1'($urandom);
        ifa.ci  = 1'($urandom);
        chk("busy_after_accept", ifa.busy, 1);
        chk("done_after_accept", ifa.done, 0);
    endtask

    task automatic wait_done16(input int unsigned e0, output int lat);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifa.done) begin
                lat = int'(cyc - e0);
                break;
            end
            chk("busy_in_run", ifa.busy, 1);
            chk("s_held", ifa.s, held_s);
            chk("cu_held", ifa.cu, held_cu);
            chk("ovf_held", ifa.ovf, held_ovf);
        end
    endtask

    task automatic finish16(input logic [15:0] x, input logic [15:0] y,
                            input logic sub, input logic ci, input int lat);
        logic [15:0] es;
        logic        ecu, eovf;
        model(16, x, y, sub, ci, es, ecu, eovf);
        chk("latency16", lat, 4);
        chk("s16", ifa.s, es);
        chk("cu16", ifa.cu, ecu);
        chk("ovf16", ifa.ovf, eovf);
        chk("busy_in_done", ifa.busy, 0);
        held_s = es; held_cu = ecu; held_ovf = eovf;
    endtask

    task automatic idle_after16();
        @(posedge clk);
        @(negedge clk);
        chk("done_drops", ifa.done, 0);
        chk("busy_idle", ifa.busy, 0);
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic sub, input logic ci);
        int unsigned e0;
        int          lat;
        start16(x, y, sub, ci, e0);
        wait_done16(e0, lat);
        finish16(x, y, sub, ci, lat);
        idle_after16();
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic sub, input logic ci);
        int unsigned e0;
        int          latb, latc;
        logic [3:0]  sb, sc;
        logic        cub, cuc, ovb, ovc;
        logic [15:0] es;
        logic        ecu, eovf;
        ifb.start = 1'b1; ifb.x = x; ifb.y = y; ifb.sub = sub; ifb.ci = ci;
        ifc.start = 1'b1; ifc.x = x; ifc.y = y; ifc.sub = sub; ifc.ci = ci;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        latb = -1; latc = -1;
        sb = '0; sc = '0; cub = 1'b0; cuc = 1'b0; ovb = 1'b0; ovc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (latb < 0 && ifb.done) begin
                latb = int'(cyc - e0); sb = ifb.s; cub = ifb.cu; ovb = ifb.ovf;
            end
            if (latc < 0 && ifc.done) begin
                latc = int'(cyc - e0); sc = ifc.s; cuc = ifc.cu; ovc = ifc.ovf;
            end
        end
        model(4, {12'h0, x}, {12'h0, y}, sub, ci, es, ecu, eovf);
        chk("lat_k1", latb, 4);
        chk("s_k1", sb, es[3:0]);
        chk("cu_k1", cub, ecu);
        chk("ovf_k1", ovb, eovf);
        chk("lat_k4", latc, 1);
        chk("s_k4", sc, es[3:0]);
        chk("cu_k4", cuc, ecu);
        chk("ovf_k4", ovc, eovf);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned e0;
        int          lat;
        logic [9:0]  v;

        ifa.start = 1'b0; ifa.sub = 1'b0; ifa.x = '0; ifa.y = '0; ifa.ci = 1'b0;
        ifb.start = 1'b0; ifb.sub = 1'b0; ifb.x = '0; ifb.y = '0; ifb.ci = 1'b0;
        ifc.start = 1'b0; ifc.sub = 1'b0; ifc.x = '0; ifc.y = '0; ifc.ci = 1'b0;
        held_s = '0; held_cu = 1'b0; held_ovf = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_s", ifa.s, 0);
        chk("rst_cu", ifa.cu, 0);
        chk("rst_ovf", ifa.ovf, 0);
        chk("rst_s_k1", ifb.s, 0);
        chk("rst_s_k4", ifc.s, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic, first start right after release
        op16(16'h0001, 16'h0001, 1'b0, 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h0005, 16'h0007, 1'b1, 1'b1);
        op16(16'h8000, 16'h0001, 1'b1, 1'b1);

        // Start pulsed two cycles into RUN is ignored
        start16(16'h1000, 16'h0234, 1'b0, 1'b0, e0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        ifa.start = 1'b1; ifa.x = 16'hABCD; ifa.y = 16'h1111; ifa.sub = 1'b1; ifa.ci = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.start = 1'b0;
        chk("busy_ignored_start", ifa.busy, 1);
        wait_done16(e0, lat);
        finish16(16'h1000, 16'h0234, 1'b0, 1'b0, lat);
        idle_after16();

        // Back-to-back: start held in the DONE cycle
        start16(16'h4321, 16'h1234, 1'b0, 1'b1, e0);
        wait_done16(e0, lat);
        finish16(16'h4321, 16'h1234, 1'b0, 1'b1, lat);
        start16(16'h0F0F, 16'h00F1, 1'b1, 1'b1, e0);
        chk("s_held_b2b", ifa.s, held_s);
        wait_done16(e0, lat);
        finish16(16'h0F0F, 16'h00F1, 1'b1, 1'b1, lat);
        idle_after16();

        // Reset mid-RUN, after chunk 1 has been processed
        start16(16'hAAAA, 16'h5555, 1'b0, 1'b0, e0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("s_before_reset", ifa.s, held_s);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", ifa.busy, 0);
        chk("arst_done", ifa.done, 0);
        chk("arst_s", ifa.s, 0);
        chk("arst_cu", ifa.cu, 0);
        chk("arst_ovf", ifa.ovf, 0);
        held_s = '0; held_cu = 1'b0; held_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_done_after_reset", ifa.done, 0);
            chk("no_busy_after_reset", ifa.busy, 0);
        end
        op16(16'h1234, 16'h1111, 1'b0, 1'b0);

        // Random 16-bit operations
        for (int i = 0; i < 150; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // Exhaustive N=4 with K=1 and K=4
        for (int i = 0; i < 1024; i++) begin
            v = 10'(i);
            op4(v[3:0], v[7:4], v[9], v[8]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor: the sequential successor to the team's combinational 4-bit ripple-carry adder. It adds or subtracts two N-bit operands K bits per clock, carrying between chunks in a register, so wide operands do not need a full-width carry chain. It adds a start/busy/done handshake, a subtract mode, and a signed-overflow flag. Its intended place is arithmetic datapaths where area matters more than latency.

## Interface
- N, 16: operand/result width; must be a positive multiple of K.
- K, 4: chunk width processed per cycle; 1 ≤ K ≤ N.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0: s = x + y + ci; 1: s = x + ~y + ci (ci=1 gives x − y).
- x  in  N  operand A, captured on accepted start.
- y  in  N  operand B, captured on accepted start.
- ci  in  1  carry-in, captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when result registers update.
- s  out  N  result; registered, held until next update.
- cu  out  1  carry out of bit N−1 (raw carry, not borrow).
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Let M = N/K. States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1, go to RUN:
  - capture x into xa;
  - capture (sub ? ~y : y) into yb;
  - carry register c = ci;
  - chunk index idx = 0.
- RUN: each cycle, add chunk idx of xa, chunk idx of yb, and c, giving a K-bit sum and carry.
  - Store the sum into chunk idx of the working register; update c; idx++.
  - On the chunk with idx = M−1, also record the carry into the MSB for ovf, then go to DONE.
- DONE (one cycle): s, cu, ovf are loaded from the working register, final carry and overflow logic. done=1.
  - If start=1 in this cycle, a new operation is accepted and the next state is RUN.
  - Otherwise the next state is IDLE.
- start while in RUN is ignored; operands are not re-captured.
- x, y, sub and ci may change freely after the accepting edge.
- s, cu, ovf change only on entry to DONE; they hold the previous result throughout RUN.
- Arithmetic is modulo 2^N; cu is the (N+1)-th bit. For sub=1, ci=1: cu=1 means no borrow (x ≥ y unsigned).
- Reset (asserted at any time, including mid-RUN):
  - state=IDLE, busy=0, done=0, s=0, cu=0, ovf=0;
  - internal registers cleared;
  - the in-flight operation is discarded.
- Degenerate case K=N: M=1, single RUN cycle.

## Timing
- Edge E0 samples start=1 in IDLE/DONE. From E0: busy=1.
- Edges E1..EM process chunks 0..M−1.
- From EM: busy=0, done=1, s/cu/ovf valid.
- From EM+1: done=0.
- Latency from start edge to done: M cycles. Throughput: one operation per M cycles with back-to-back start in DONE.
- done and busy are never high together.
- Reset is asynchronous: outputs go to reset values without waiting for clk. Release is synchronous to the next rising edge; the first start is accepted at the first edge after release.

## Test plan
- N=16, K=4, sub=0, x=0x0001, y=0x0001, ci=0 -> done exactly 4 cycles after the start edge; s=0x0002, cu=0, ovf=0; busy high for 4 cycles.
- x=0xFFFF, y=0x0001, ci=0 (carry ripples through all chunks) -> s=0x0000, cu=1, ovf=0. Then x=0x7FFF, y=0x0001 -> s=0x8000, cu=0, ovf=1.
- sub=1, ci=1, x=0x0005, y=0x0007 -> s=0xFFFE, cu=0, ovf=0. Then x=0x8000, y=0x0001 -> s=0x7FFF, cu=1, ovf=1.
- Handshake:
  - pulse start again 2 cycles into RUN with different operands -> ignored, first result unchanged;
  - start held high in the DONE cycle -> second operation accepted, second done 4 cycles later;
  - s holds the first result until then.
- Assert rst_n=0 mid-RUN (after chunk 1) -> busy, done, s, cu, ovf drop to 0 asynchronously and no done follows. After release, 0x1234+0x1111 -> s=0x2345.
- Parameter sweep N=4, K=1 and N=4, K=4: exhaustive x, y, ci, sub -> s and cu match {cu,s} = x + (sub ? ~y : y) + ci; ovf matches the signed reference; latency 4 and 1 cycles respectively.
